byte_lookup_mem: RTL and testbench
==================================

Name: byte_lookup_mem

Overview:
- 256-entry x 8-bit on-chip lookup memory, read through a strobed, address-indexed port.
- Contents power up and reset to an identity pattern (entry i holds value i).
- Optional synchronous write port overwrites entries.
- Sits behind the memory interface bundle (modport carrying clk, en, wr, addr in / data out) and serves the testbench clocking-block driver.

Parameters:
- DATA_W, 8, width of each entry and of data/wdata.
- ADDR_W, 8, address width.
- DEPTH, 256, number of entries; must equal 2**ADDR_W.
- INIT_IDENTITY, 1, 1 = entry i initialised to i[DATA_W-1:0] on reset; 0 = all entries reset to 0.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  port enable.
- wr  input  1  read strobe qualifier (legacy name); a read is active when en && wr.
- addr  input  ADDR_W  entry index for read and write.
- we  input  1  write enable; tie 0 for read-only use.
- wdata  input  DATA_W  write data.
- data  output  DATA_W  read data.

Behaviour:
- One clock domain and one reset. Reset is asynchronous, active-low.
- Reset (rst_n=0, asynchronous assert, synchronous-safe deassert):
  - all entries load the init pattern (identity when INIT_IDENTITY=1);
  - the data hold register clears to 0;
  - data reads 0 while in reset.
- Read path, zero latency:
  - When en && wr: data = mem[addr] combinationally. Address changes between edges propagate to data within the same cycle.
  - When !(en && wr): data = hold register. This is the last value returned by an active read, captured at each rising edge where en && wr.
  - No latches. The hold register is a flop.
- Write path, synchronous:
  - At the rising edge, if en && we, then mem[addr] <= wdata.
  - Write is independent of wr.
- Simultaneous read and write to the same address in one cycle:
  - data shows the old content during the cycle;
  - the new content is visible from the next cycle;
  - the hold register captures the old value.
- Write with en=0: ignored. we with en=0: no effect.
- Reset during a write cycle: reset wins; the entry returns to its init value.
- Address is always in range (DEPTH = 2**ADDR_W); there is no wrap or error condition.
- No handshake, no backpressure. Every active read and write completes in the cycle it is presented.

Test Plan:
- Reset, then en=1, wr=1, addr=3 -> data=3 the same cycle; addr=15 -> 15; addr=20 -> 20; addr=22 -> 22.
- After a read of addr=22, drop en to 0 and change addr to 5 -> data holds 22 across subsequent edges.
- en=1, we=1, wr=0, addr=40, wdata=8'hA5 for one edge; then wr=1, we=0, addr=40 -> data=8'hA5. Also read addr=41 -> 41 (unaffected).
- Same-cycle en=1, wr=1, we=1, addr=7, wdata=8'h5A -> data=7 in that cycle; the next cycle's read of addr 7 -> 8'h5A.
- Write 8'hFF to addr=0, then pulse rst_n low mid-cycle -> data=0 immediately. After release, a read of addr=0 returns 0 (identity) and a read of addr=255 returns 255.
- Sweep addr 0..255 with en=wr=1 -> data equals addr at every step. With INIT_IDENTITY=0, every entry reads 0.

Source files
------------

// File: rtl/byte_lookup_mem.sv
// byte_lookup_mem: flop-based lookup table with a zero-latency strobed read
// port, a hold register for the last read value, and a synchronous write port.
module byte_lookup_mem #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned INIT_IDENTITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned INIT_ID = (INIT_IDENTITY != 0) ? 1 : 0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] hold;
  logic              rd_act;
  logic              wr_act;
  logic [DATA_W-1:0] rd_word;

  assign rd_act  = en && wr;
  assign wr_act  = en && we;
  assign rd_word = mem[addr];

  // Storage: reset restores the init pattern; writes land at the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= (INIT_ID == 1) ? DATA_W'(i) : '0;
      end
    end else if (wr_act) begin
      mem[addr] <= wdata;
    end
  end

  // Hold register: captures the pre-write word returned by each active read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (rd_act) begin
      hold <= rd_word;
    end
  end

  // Read mux: live word while strobed, otherwise the held value; 0 in reset.
  always_comb begin
    data = hold;
    if (!rst_n) begin
      data = '0;
    end else if (rd_act) begin
      data = rd_word;
    end
  end

endmodule

// File: tb/tb_byte_lookup_mem.sv
// Self-checking bench for byte_lookup_mem: directed test-plan steps plus
// random traffic against an array-based reference, on identity and zero-init
// instances sharing the same stimulus.
module tb_byte_lookup_mem;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr;
  logic [7:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] data_id;
  logic [7:0] data_z;

  int checks = 0;
  int fails  = 0;

  logic [7:0] ref_id [256];
  logic [7:0] ref_z  [256];
  logic [7:0] hold_id;
  logic [7:0] hold_z;

  byte_lookup_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_IDENTITY(1)) dut_id (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .addr(addr),
    .we(we), .wdata(wdata), .data(data_id)
  );

  byte_lookup_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_IDENTITY(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .addr(addr),
    .we(we), .wdata(wdata), .data(data_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      ref_id[i] = 8'(i);
      ref_z[i]  = 8'h00;
    end
    hold_id = 8'h00;
    hold_z  = 8'h00;
  endtask

  function automatic logic [7:0] exp_id();
    if (!rst_n) return 8'h00;
    if (en && wr) return ref_id[addr];
    return hold_id;
  endfunction

  function automatic logic [7:0] exp_z();
    if (!rst_n) return 8'h00;
    if (en && wr) return ref_z[addr];
    return hold_z;
  endfunction

  // Compare both instances against the reference model.
  task automatic check_model(input string tag);
    check({tag, "_id"}, data_id, exp_id());
    check({tag, "_z"}, data_z, exp_z());
  endtask

  // Apply the edge's effect to the model from the inputs now present, then
  // advance to just after the rising edge.
  task automatic tick();
    if (rst_n) begin
      if (en && wr) begin
        hold_id = ref_id[addr];
        hold_z  = ref_z[addr];
      end
      if (en && we) begin
        ref_id[addr] = wdata;
        ref_z[addr]  = wdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    wr    = 1'b0;
    we    = 1'b0;
    addr  = 8'h00;
    wdata = 8'h00;
    model_reset();

    // Reset state
    #2;
    check("reset_id", data_id, 8'h00);
    check("reset_z", data_z, 8'h00);
    #10;
    rst_n = 1'b1;
    tick();
    check_model("post_reset");

    // Zero-latency reads, with address changes inside one cycle
    en = 1'b1; wr = 1'b1; addr = 8'd3;
    #1 check("rd3", data_id, 8'd3);
    addr = 8'd15;
    #1 check("rd15", data_id, 8'd15);
    tick();
    addr = 8'd20;
    #1 check("rd20", data_id, 8'd20);
    addr = 8'd22;
    #1 check("rd22", data_id, 8'd22);
    check("rd22_z", data_z, 8'h00);
    tick();

    // Hold register keeps the last active read
    en = 1'b0; addr = 8'd5;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold22", data_id, 8'd22);
      tick();
    end

    // Write without read strobe, then read back
    en = 1'b1; we = 1'b1; wr = 1'b0; addr = 8'd40; wdata = 8'hA5;
    #1 check("wr_hold", data_id, 8'd22);
    tick();
    we = 1'b0; wr = 1'b1;
    #1 check("rd40", data_id, 8'hA5);
    check("rd40_z", data_z, 8'hA5);
    addr = 8'd41;
    #1 check("rd41", data_id, 8'd41);
    tick();

    // Write with en low is ignored
    en = 1'b0; we = 1'b1; addr = 8'd50; wdata = 8'h11;
    tick();
    en = 1'b1; we = 1'b0; wr = 1'b1;
    #1 check("noen_wr", data_id, 8'd50);
    tick();

    // Same-cycle read and write to one address
    en = 1'b1; wr = 1'b1; we = 1'b1; addr = 8'd7; wdata = 8'h5A;
    #1 check("rw_old", data_id, 8'd7);
    tick();
    we = 1'b0; wr = 1'b0;
    #1 check("rw_hold_old", data_id, 8'd7);
    wr = 1'b1;
    #1 check("rw_new", data_id, 8'h5A);
    tick();

    // Asynchronous reset after a write restores identity
    en = 1'b1; we = 1'b1; wr = 1'b0; addr = 8'd0; wdata = 8'hFF;
    tick();
    we = 1'b0; wr = 1'b1;
    #1 check("rd0_ff", data_id, 8'hFF);
    rst_n = 1'b0;
    model_reset();
    #1 check("rst_mid_id", data_id, 8'h00);
    check("rst_mid_z", data_z, 8'h00);
    #1 rst_n = 1'b1;
    #1 check("rd0_after_rst", data_id, 8'h00);
    addr = 8'd255;
    #1 check("rd255_after_rst", data_id, 8'd255);
    tick();

    // Reset held across a write edge: reset wins
    we = 1'b1; wr = 1'b0; addr = 8'd9; wdata = 8'h33;
    rst_n = 1'b0;
    model_reset();
    tick();
    #1 rst_n = 1'b1;
    we = 1'b0; wr = 1'b1;
    #1 check("rst_wins", data_id, 8'd9);
    tick();

    // Full address sweep on freshly reset contents
    for (int a = 0; a < 256; a++) begin
      addr = 8'(a);
      #1;
      check("sweep_id", data_id, 8'(a));
      check("sweep_z", data_z, 8'h00);
      tick();
    end

    // Random traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      en    = 1'($urandom_range(0, 3) != 0);
      wr    = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = 8'($urandom_range(0, 31));
      wdata = 8'($urandom);
      #1 check_model("rand_a");
      addr = 8'($urandom_range(0, 31));
      #1 check_model("rand_b");
      tick();
      check_model("rand_c");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
